// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one single-port memory with fixed-latency access timing
// Optional macro ARB_PERF_CNT_EN adds stall and conflict performance counters.
module mem_port_arbiter #(
  parameter int LAT            = 2,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_if,
  output logic        stall_all
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_conflict
`endif
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [2:0]    LAT_C = 3'(LAT);
  localparam logic [SW-1:0] MAX_C = SW'(MAX_MEM_STREAK);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            owner_if_q, owner_if_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_if_q <= owner_if_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_if_d = owner_if_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if_ready   = 1'b0;
    if_rdata   = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    stall_if   = 1'b0;
    stall_all  = 1'b0;
    // IF only overtakes MEM once it has watched MAX_MEM_STREAK MEM grants go by
    grant_if   = if_req && (!mem_req || (streak_q == MAX_C));

    // Outputs are forced low while reset is held, even with requests pending
    if (rst_n) begin
      if (state_q == IDLE) begin
        if (if_req || mem_req) begin
          ram_en = 1'b1;
          if (grant_if) begin
            ram_addr   = if_addr;
            owner_if_d = 1'b1;
            we_d       = 1'b0;
            addr_d     = if_addr;
            wdata_d    = '0;
            streak_d   = '0;
          end else begin
            ram_we     = mem_we;
            ram_addr   = mem_addr;
            ram_wdata  = mem_wdata;
            owner_if_d = 1'b0;
            we_d       = mem_we;
            addr_d     = mem_addr;
            wdata_d    = mem_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != MAX_C) begin
              streak_d = streak_q + 1'b1;
            end
          end
          cnt_d   = LAT_C;
          state_d = BUSY;
        end
      end else begin
        ram_we    = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (owner_if_q) begin
            if_ready = 1'b1;
            if_rdata = ram_rdata;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = we_q ? 32'd0 : ram_rdata;
          end
        end
      end
      stall_if  = if_req & ~if_ready;
      stall_all = mem_req & ~mem_ready;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_cf_q, perf_cf_d;

  always_comb begin
    perf_if_d  = perf_if_q + {31'd0, stall_if};
    perf_mem_d = perf_mem_q + {31'd0, stall_all};
    perf_cf_d  = perf_cf_q + {31'd0, (state_q == IDLE) && if_req && mem_req};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q  <= '0;
      perf_mem_q <= '0;
      perf_cf_q  <= '0;
    end else begin
      perf_if_q  <= perf_if_d;
      perf_mem_q <= perf_mem_d;
      perf_cf_q  <= perf_cf_d;
    end
  end

  assign perf_if_stall  = perf_if_q;
  assign perf_mem_stall = perf_mem_q;
  assign perf_conflict  = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (LAT=2 and LAT=1 instances)
// Directed scenarios plus randomized traffic against a cycle-number based reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, mem_req, mem_we, if_ready, mem_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_rdata, mem_rdata;
  logic        ram_en, ram_we, stall_if, stall_all;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        b_if_req, b_mem_req, b_mem_we, b_if_ready, b_mem_ready;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_if_rdata, b_mem_rdata;
  logic        b_ram_en, b_ram_we, b_stall_if, b_stall_all;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_mem_stall, perf_conflict;
  logic [31:0] b_perf_if_stall, b_perf_mem_stall, b_perf_conflict;
`endif

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.LAT(LAT), .MAX_MEM_STREAK(MAXS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_all(stall_all)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall), .perf_conflict(perf_conflict)
`endif
  );

  mem_port_arbiter #(.LAT(1), .MAX_MEM_STREAK(MAXS)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .stall_if(b_stall_if), .stall_all(b_stall_all)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(b_perf_if_stall), .perf_mem_stall(b_perf_mem_stall), .perf_conflict(b_perf_conflict)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_we = 0; b_mem_addr = '0; b_mem_wdata = '0;
    b_ram_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    if_req = 1; mem_req = 1; mem_addr = 32'h44; b_if_req = 1; b_mem_req = 1;
    step();
    smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_all, if_ready, mem_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0", {ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_all, if_ready, mem_ready});
    end
    checks++;
    if ({if_rdata, mem_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_rdata got=%0h exp=0", {if_rdata, mem_rdata});
    end
    checks++;
    if ({b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata, b_stall_if, b_stall_all, b_mem_ready, b_mem_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_lat1 got=%0h exp=0", {b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata, b_stall_if, b_stall_all, b_mem_ready, b_mem_rdata});
    end
    clear_inputs();
    step();
    rst_n = 1;
    smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL idle_no_req_ram got=%0h exp=0", {ram_en, ram_we, ram_addr, ram_wdata});
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({perf_if_stall, perf_mem_stall, perf_conflict} !== '0) begin
      failures++;
      $display("FAIL reset_perf got=%0h exp=0", {perf_if_stall, perf_mem_stall, perf_conflict});
    end
`endif
    step();
  endtask

  task automatic test_if_single();
    do_reset();
    if_req = 1; if_addr = 32'h10;
    smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, stall_if, if_ready} !== {1'b1, 1'b0, 32'h10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL if_single_c0 got=%0h exp=%0h", {ram_en, ram_we, ram_addr, stall_if, if_ready}, {1'b1, 1'b0, 32'h10, 1'b1, 1'b0});
    end
    step(); ram_rdata = 32'hFFFF_FFFF; smp();
    checks++;
    if ({ram_en, if_ready, stall_if} !== 3'b001) begin
      failures++;
      $display("FAIL if_single_c1 got=%b exp=001", {ram_en, if_ready, stall_if});
    end
    step(); ram_rdata = 32'h8C22_0004; smp();
    checks++;
    if ({if_ready, stall_if, if_rdata} !== {1'b1, 1'b0, 32'h8C22_0004}) begin
      failures++;
      $display("FAIL if_single_c2 got=%0h exp=%0h", {if_ready, stall_if, if_rdata}, {1'b1, 1'b0, 32'h8C22_0004});
    end
    step(); if_addr = 32'h14; ram_rdata = '0; smp();
    checks++;
    if ({ram_en, ram_addr} !== {1'b1, 32'h14}) begin
      failures++;
      $display("FAIL if_single_c3_regrant got=%0h exp=%0h", {ram_en, ram_addr}, {1'b1, 32'h14});
    end
    if_req = 0;
    repeat (3) step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1; if_addr = 32'h20;
    mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, stall_all, stall_if} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL simul_c0_mem_grant got=%0h exp=%0h", {ram_en, ram_we, ram_addr, ram_wdata, stall_all, stall_if}, {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1});
    end
    step(); smp();
    checks++;
    if ({ram_en, mem_ready, stall_all} !== 3'b001) begin
      failures++;
      $display("FAIL simul_c1 got=%b exp=001", {ram_en, mem_ready, stall_all});
    end
    step(); ram_rdata = 32'h1234_5678; smp();
    checks++;
    if ({mem_ready, stall_all, if_ready, stall_if, mem_rdata} !== {4'b1001, 32'h0}) begin
      failures++;
      $display("FAIL simul_c2_mem_ready got=%0h exp=%0h", {mem_ready, stall_all, if_ready, stall_if, mem_rdata}, {4'b1001, 32'h0});
    end
    step(); mem_req = 0; mem_we = 0; smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, stall_all, stall_if} !== {1'b1, 1'b0, 32'h20, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL simul_c3_if_grant got=%0h exp=%0h", {ram_en, ram_we, ram_addr, stall_all, stall_if}, {1'b1, 1'b0, 32'h20, 1'b0, 1'b1});
    end
    step();
    step(); ram_rdata = 32'hCAFE_F00D; smp();
    checks++;
    if ({if_ready, stall_if, if_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL simul_c5_if_ready got=%0h exp=%0h", {if_ready, stall_if, if_rdata}, {1'b1, 1'b0, 32'hCAFE_F00D});
    end
    step(); if_req = 0; smp();
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({perf_conflict, perf_mem_stall, perf_if_stall} !== {32'd1, 32'd2, 32'd5}) begin
      failures++;
      $display("FAIL simul_perf got=%0h/%0h/%0h exp=1/2/5", perf_conflict, perf_mem_stall, perf_if_stall);
    end
`endif
    step();
  endtask

  task automatic test_streak();
    int ng = 0;
    int last = 0;
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_req = 1; mem_we = 0; mem_addr = 32'h200;
    for (int cyc = 0; cyc < 100 && ng < 10; cyc++) begin
      smp();
      if (ram_en === 1'b1) begin
        checks++;
        if (ram_addr !== ((ng % 5 == 4) ? 32'h40 : 32'h200)) begin
          failures++;
          $display("FAIL streak_order grant=%0d got=%0h exp=%0h", ng, ram_addr, (ng % 5 == 4) ? 32'h40 : 32'h200);
        end
        if (ng > 0) begin
          checks++;
          if (cyc - last !== LAT + 1) begin
            failures++;
            $display("FAIL streak_spacing grant=%0d got=%0d exp=%0d", ng, cyc - last, LAT + 1);
          end
        end
        last = cyc;
        ng++;
      end
      step();
    end
    checks++;
    if (ng !== 10) begin
      failures++;
      $display("FAIL streak_timeout got=%0d exp=10", ng);
    end
    clear_inputs();
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req = 1; mem_we = 0; mem_addr = 32'h300;
    smp();
    checks++;
    if ({ram_en, ram_addr} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL rstmid_grant got=%0h exp=%0h", {ram_en, ram_addr}, {1'b1, 32'h300});
    end
    step(); rst_n = 0; #1; smp();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, mem_ready, mem_rdata, stall_all, stall_if, if_ready, if_rdata} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%0h exp=0", {ram_en, ram_addr, mem_ready, mem_rdata, stall_all});
    end
    step(); ram_rdata = 32'hBAD0_BAD0; smp();
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_ready got=%b exp=0", mem_ready);
    end
    step(); rst_n = 1; ram_rdata = 32'h0; smp();
    checks++;
    if ({ram_en, ram_addr, mem_ready, stall_all} !== {1'b1, 32'h300, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_regrant got=%0h exp=%0h", {ram_en, ram_addr, mem_ready, stall_all}, {1'b1, 32'h300, 1'b0, 1'b1});
    end
    step(); smp();
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_early_ready got=%b exp=0", mem_ready);
    end
    step(); ram_rdata = 32'h0BAD_F00D; smp();
    checks++;
    if ({mem_ready, mem_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      failures++;
      $display("FAIL rstmid_ready got=%0h exp=%0h", {mem_ready, mem_rdata}, {1'b1, 32'h0BAD_F00D});
    end
    step(); clear_inputs(); step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    b_if_req = 1; b_if_addr = 32'h0;
    smp();
    checks++;
    if ({b_ram_en, b_ram_addr, b_if_ready} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_c0 got=%0h exp=%0h", {b_ram_en, b_ram_addr, b_if_ready}, {1'b1, 32'h0, 1'b0});
    end
    step(); b_ram_rdata = 32'h1111_1111; smp();
    checks++;
    if ({b_if_ready, b_if_rdata, b_stall_if} !== {1'b1, 32'h1111_1111, 1'b0}) begin
      failures++;
      $display("FAIL b2b_c1 got=%0h exp=%0h", {b_if_ready, b_if_rdata, b_stall_if}, {1'b1, 32'h1111_1111, 1'b0});
    end
    step(); b_if_addr = 32'h4; b_ram_rdata = '0; smp();
    checks++;
    if ({b_ram_en, b_ram_addr, b_if_ready} !== {1'b1, 32'h4, 1'b0}) begin
      failures++;
      $display("FAIL b2b_c2 got=%0h exp=%0h", {b_ram_en, b_ram_addr, b_if_ready}, {1'b1, 32'h4, 1'b0});
    end
    step(); b_ram_rdata = 32'h2222_2222; smp();
    checks++;
    if ({b_if_ready, b_if_rdata} !== {1'b1, 32'h2222_2222}) begin
      failures++;
      $display("FAIL b2b_c3 got=%0h exp=%0h", {b_if_ready, b_if_rdata}, {1'b1, 32'h2222_2222});
    end
    step(); clear_inputs(); step();
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] ram_m [logic [31:0]];

  function automatic logic [31:0] ram_read(logic [31:0] a);
    return ram_m.exists(a) ? ram_m[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Model: a grant happens on any cycle >= free_at with a request pending;
  // the result returns exactly LAT cycles after the grant.
  task automatic test_random();
    rd_t         rq[$];
    rd_t         e;
    bit          if_act = 0, mem_act = 0, g, wif, er_if, er_mem, own_if = 0, own_wr = 0;
    int          free_at = 0, ready_at = -1, streak = 0;
    logic [31:0] exp_data = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1;
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!mem_act && $urandom_range(0, 2) == 0) begin
        mem_act = 1;
        mem_we = 1'($urandom_range(0, 1));
        mem_addr = 32'($urandom_range(0, 15)) << 2;
        mem_wdata = $urandom;
      end
      if_req = if_act;
      mem_req = mem_act;
      if (rq.size() > 0 && rq[0].due <= c) begin
        ram_rdata = rq[0].d;
        rq.pop_front();
      end else begin
        ram_rdata = $urandom;
      end
      smp();
      g = (c >= free_at) && (if_act || mem_act);
      wif = if_act && (!mem_act || streak == MAXS);
      er_if = (c == ready_at) && own_if;
      er_mem = (c == ready_at) && !own_if;
      checks++;
      if (ram_en !== g) begin
        failures++;
        $display("FAIL rand_ram_en cyc=%0d got=%b exp=%b", c, ram_en, g);
      end
      if (g) begin
        checks++;
        if ({ram_addr, ram_we} !== {wif ? if_addr : mem_addr, wif ? 1'b0 : mem_we} ||
            (!wif && mem_we && ram_wdata !== mem_wdata)) begin
          failures++;
          $display("FAIL rand_grant cyc=%0d got=%0h/%b/%0h exp=%0h/%b", c, ram_addr, ram_we, ram_wdata, wif ? if_addr : mem_addr, wif ? 1'b0 : mem_we);
        end
      end
      checks++;
      if ({if_ready, mem_ready} !== {er_if, er_mem}) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", c, if_ready, mem_ready, er_if, er_mem);
      end
      if (er_if) begin
        checks++;
        if (if_rdata !== exp_data) begin
          failures++;
          $display("FAIL rand_if_rdata cyc=%0d got=%0h exp=%0h", c, if_rdata, exp_data);
        end
      end
      if (er_mem) begin
        checks++;
        if (mem_rdata !== (own_wr ? 32'h0 : exp_data)) begin
          failures++;
          $display("FAIL rand_mem_rdata cyc=%0d got=%0h exp=%0h", c, mem_rdata, own_wr ? 32'h0 : exp_data);
        end
      end
      checks++;
      if ({stall_if, stall_all} !== {if_act && !er_if, mem_act && !er_mem}) begin
        failures++;
        $display("FAIL rand_stall cyc=%0d got=%b%b exp=%b%b", c, stall_if, stall_all, if_act && !er_if, mem_act && !er_mem);
      end
      if (g) begin
        ready_at = c + LAT;
        free_at = c + LAT + 1;
        own_if = wif;
        own_wr = !wif && mem_we;
        exp_data = ram_read(wif ? if_addr : mem_addr);
        if (wif || !if_act) streak = 0;
        else if (streak < MAXS) streak++;
      end
      if (ram_en === 1'b1) begin
        if (ram_we === 1'b1) begin
          ram_m[ram_addr] = ram_wdata;
        end else begin
          e.due = c + LAT;
          e.d = ram_read(ram_addr);
          rq.push_back(e);
        end
      end
      if (if_ready === 1'b1) if_act = 0;
      if (mem_ready === 1'b1) mem_act = 0;
      step();
    end
    clear_inputs();
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_if_single();
    test_simultaneous();
    test_streak();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
